// File: rtl/axi_arbiter.sv
// Two-master, one-slave AXI-lite arbiter in front of the memory port.
// The IFU read channel and the LSU read/write channels share a single memory
// interface. Reads are arbitrated round-robin (RR_EN=1) or fixed priority with
// the LSU winning ties (RR_EN=0). Each channel has at most one single-beat
// transaction in flight, and memory valids are gated so a request is seen once.
//
// Ports:
//   clock, reset          clock, synchronous active-high reset
//   ifu_ar*/ifu_r*        IFU read request (in) and response (out)
//   lsu_ar*/lsu_r*        LSU read request (in) and response (out)
//   lsu_aw*/lsu_w*/lsu_b* LSU write request (in) and response (out)
//   mem_ar*/mem_r*        read request to memory (out), response (in)
//   mem_aw*/mem_w*/mem_b* write request to memory (out), response (in)
module axi_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  // IFU read
  input  logic        ifu_arvalid_i,
  input  logic [31:0] ifu_araddr_i,
  input  logic        ifu_rready_i,
  output logic        ifu_arready_o,
  output logic        ifu_rvalid_o,
  output logic [31:0] ifu_rdata_o,
  output logic        ifu_rlast_o,
  // LSU read
  input  logic        lsu_arvalid_i,
  input  logic [31:0] lsu_araddr_i,
  input  logic        lsu_rready_i,
  output logic        lsu_arready_o,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_rlast_o,
  // LSU write
  input  logic        lsu_awvalid_i,
  input  logic [31:0] lsu_awaddr_i,
  input  logic        lsu_wvalid_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [3:0]  lsu_wstrb_i,
  input  logic        lsu_bready_i,
  output logic        lsu_awready_o,
  output logic        lsu_wready_o,
  output logic        lsu_bvalid_o,
  // Memory read
  output logic        mem_arvalid_o,
  output logic [31:0] mem_araddr_o,
  output logic        mem_rready_o,
  input  logic        mem_arready_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_rlast_i,
  // Memory write
  output logic        mem_awvalid_o,
  output logic [31:0] mem_awaddr_o,
  output logic        mem_wvalid_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  output logic        mem_bready_o,
  input  logic        mem_awready_i,
  input  logic        mem_wready_i,
  input  logic        mem_bvalid_i
);

  typedef enum logic [1:0] {RIdle, RAddr, RData} r_state_e;
  typedef enum logic {WIdle, WResp} w_state_e;
  typedef enum logic {MIfu, MLsu} master_e;

  r_state_e r_state_q, r_state_d;
  w_state_e w_state_q, w_state_d;
  master_e  grant_q, grant_d;
  master_e  last_q, last_d;

  logic w_idle;
  logic lsu_cand;
  logic gnt_arvalid;
  logic gnt_rready;

  assign w_idle = (w_state_q == WIdle);

  // Store-before-load: an LSU read waits while a write is in flight, including
  // one being offered this cycle, so its AR follows the write response.
  assign lsu_cand = lsu_arvalid_i & w_idle & ~lsu_awvalid_i & ~lsu_wvalid_i;

  assign gnt_arvalid = (grant_q == MLsu) ? lsu_arvalid_i : ifu_arvalid_i;
  assign gnt_rready  = (grant_q == MLsu) ? lsu_rready_i  : ifu_rready_i;

  // Read channel outputs
  always_comb begin
    mem_arvalid_o = (r_state_q == RAddr) & gnt_arvalid;
    mem_araddr_o  = (grant_q == MLsu) ? lsu_araddr_i : ifu_araddr_i;
    mem_rready_o  = (r_state_q == RData) & gnt_rready;
    ifu_arready_o = (r_state_q == RAddr) & (grant_q == MIfu) & mem_arready_i;
    lsu_arready_o = (r_state_q == RAddr) & (grant_q == MLsu) & mem_arready_i;
    ifu_rvalid_o  = (r_state_q == RData) & (grant_q == MIfu) & mem_rvalid_i;
    lsu_rvalid_o  = (r_state_q == RData) & (grant_q == MLsu) & mem_rvalid_i;
    ifu_rdata_o   = mem_rdata_i;
    lsu_rdata_o   = mem_rdata_i;
    ifu_rlast_o   = mem_rlast_i;
    lsu_rlast_o   = mem_rlast_i;
  end

  // Write channel outputs
  always_comb begin
    mem_awvalid_o = w_idle & lsu_awvalid_i;
    mem_wvalid_o  = w_idle & lsu_wvalid_i;
    mem_awaddr_o  = lsu_awaddr_i;
    mem_wdata_o   = lsu_wdata_i;
    mem_wstrb_o   = lsu_wstrb_i;
    lsu_awready_o = w_idle & mem_awready_i;
    lsu_wready_o  = w_idle & mem_wready_i;
    mem_bready_o  = ~w_idle & lsu_bready_i;
    lsu_bvalid_o  = ~w_idle & mem_bvalid_i;
  end

  // Read FSM next state
  always_comb begin
    r_state_d = r_state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    unique case (r_state_q)
      RIdle: begin
        if (ifu_arvalid_i || lsu_cand) begin
          if (ifu_arvalid_i && lsu_cand) begin
            if (RR_EN) grant_d = (last_q == MIfu) ? MLsu : MIfu;
            else       grant_d = MLsu;
          end else begin
            grant_d = lsu_cand ? MLsu : MIfu;
          end
          last_d    = grant_d;
          r_state_d = RAddr;
        end
      end
      RAddr: if (mem_arvalid_o && mem_arready_i) r_state_d = RData;
      RData: if (mem_rvalid_i && mem_rready_o) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  // Write FSM next state
  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      WIdle: if (mem_awvalid_o && mem_wvalid_o && mem_awready_i && mem_wready_i) w_state_d = WResp;
      WResp: if (mem_bvalid_i && lsu_bready_i) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  // Last = LSU out of reset so the first tie goes to the IFU.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_q <= RIdle;
      w_state_q <= WIdle;
      grant_q   <= MIfu;
      last_q    <= MLsu;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
    end
  end

endmodule

// File: tb/tb_axi_arbiter.sv
module tb_axi_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready;
  logic [31:0] ifu_araddr, lsu_araddr;
  logic        lsu_awvalid, lsu_wvalid, lsu_bready;
  logic [31:0] lsu_awaddr, lsu_wdata;
  logic [3:0]  lsu_wstrb;

  logic        ifu_arready, ifu_rvalid, ifu_rlast, lsu_arready, lsu_rvalid, lsu_rlast;
  logic [31:0] ifu_rdata, lsu_rdata;
  logic        lsu_awready, lsu_wready, lsu_bvalid;
  logic        mem_arvalid, mem_rready, mem_awvalid, mem_wvalid, mem_bready;
  logic [31:0] mem_araddr, mem_awaddr, mem_wdata;
  logic [3:0]  mem_wstrb;

  // Memory model
  logic        m_arready, m_awready, m_wready;
  logic        m_rvalid = 1'b0, m_bvalid = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  logic [31:0] m_mem [0:255];
  logic [31:0] ar_log [0:15];
  int          ar_cnt = 0;
  int          w_cnt = 0;

  // Fixed-priority instance outputs
  logic        fp_ifu_arready, fp_ifu_rvalid, fp_ifu_rlast, fp_lsu_arready, fp_lsu_rvalid;
  logic        fp_lsu_rlast, fp_lsu_awready, fp_lsu_wready, fp_lsu_bvalid;
  logic        fp_mem_arvalid, fp_mem_rready, fp_mem_awvalid, fp_mem_wvalid, fp_mem_bready;
  logic [31:0] fp_ifu_rdata, fp_lsu_rdata, fp_mem_araddr, fp_mem_awaddr, fp_mem_wdata;
  logic [3:0]  fp_mem_wstrb;
  int          fp_ar_cnt = 0;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  assign m_arready = ~reset;
  assign m_awready = ~reset;
  assign m_wready  = ~reset;

  axi_arbiter #(.RR_EN(1'b1)) dut (
    .clock(clock), .reset(reset),
    .ifu_arvalid_i(ifu_arvalid), .ifu_araddr_i(ifu_araddr), .ifu_rready_i(ifu_rready),
    .ifu_arready_o(ifu_arready), .ifu_rvalid_o(ifu_rvalid), .ifu_rdata_o(ifu_rdata),
    .ifu_rlast_o(ifu_rlast),
    .lsu_arvalid_i(lsu_arvalid), .lsu_araddr_i(lsu_araddr), .lsu_rready_i(lsu_rready),
    .lsu_arready_o(lsu_arready), .lsu_rvalid_o(lsu_rvalid), .lsu_rdata_o(lsu_rdata),
    .lsu_rlast_o(lsu_rlast),
    .lsu_awvalid_i(lsu_awvalid), .lsu_awaddr_i(lsu_awaddr), .lsu_wvalid_i(lsu_wvalid),
    .lsu_wdata_i(lsu_wdata), .lsu_wstrb_i(lsu_wstrb), .lsu_bready_i(lsu_bready),
    .lsu_awready_o(lsu_awready), .lsu_wready_o(lsu_wready), .lsu_bvalid_o(lsu_bvalid),
    .mem_arvalid_o(mem_arvalid), .mem_araddr_o(mem_araddr), .mem_rready_o(mem_rready),
    .mem_arready_i(m_arready), .mem_rvalid_i(m_rvalid), .mem_rdata_i(m_rdata),
    .mem_rlast_i(1'b1),
    .mem_awvalid_o(mem_awvalid), .mem_awaddr_o(mem_awaddr), .mem_wvalid_o(mem_wvalid),
    .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb), .mem_bready_o(mem_bready),
    .mem_awready_i(m_awready), .mem_wready_i(m_wready), .mem_bvalid_i(m_bvalid)
  );

  // Fixed-priority instance against an always-ready, always-responding slave
  axi_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clock(clock), .reset(reset),
    .ifu_arvalid_i(ifu_arvalid), .ifu_araddr_i(ifu_araddr), .ifu_rready_i(ifu_rready),
    .ifu_arready_o(fp_ifu_arready), .ifu_rvalid_o(fp_ifu_rvalid), .ifu_rdata_o(fp_ifu_rdata),
    .ifu_rlast_o(fp_ifu_rlast),
    .lsu_arvalid_i(lsu_arvalid), .lsu_araddr_i(lsu_araddr), .lsu_rready_i(lsu_rready),
    .lsu_arready_o(fp_lsu_arready), .lsu_rvalid_o(fp_lsu_rvalid), .lsu_rdata_o(fp_lsu_rdata),
    .lsu_rlast_o(fp_lsu_rlast),
    .lsu_awvalid_i(lsu_awvalid), .lsu_awaddr_i(lsu_awaddr), .lsu_wvalid_i(lsu_wvalid),
    .lsu_wdata_i(lsu_wdata), .lsu_wstrb_i(lsu_wstrb), .lsu_bready_i(lsu_bready),
    .lsu_awready_o(fp_lsu_awready), .lsu_wready_o(fp_lsu_wready), .lsu_bvalid_o(fp_lsu_bvalid),
    .mem_arvalid_o(fp_mem_arvalid), .mem_araddr_o(fp_mem_araddr), .mem_rready_o(fp_mem_rready),
    .mem_arready_i(1'b1), .mem_rvalid_i(1'b1), .mem_rdata_i(32'h0), .mem_rlast_i(1'b1),
    .mem_awvalid_o(fp_mem_awvalid), .mem_awaddr_o(fp_mem_awaddr), .mem_wvalid_o(fp_mem_wvalid),
    .mem_wdata_o(fp_mem_wdata), .mem_wstrb_o(fp_mem_wstrb), .mem_bready_o(fp_mem_bready),
    .mem_awready_i(1'b1), .mem_wready_i(1'b1), .mem_bvalid_i(1'b0)
  );

  function automatic logic [7:0] idx(input logic [31:0] a);
    return {a[31], a[14:8]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_rvalid         <= 1'b0;
      m_bvalid         <= 1'b0;
      m_mem[8'h80]     <= 32'h0000_0413;
      m_mem[8'h01]     <= 32'h1111_1111;
      m_mem[8'h02]     <= 32'h2222_2222;
      m_mem[8'h10]     <= 32'h0;
      m_mem[8'h20]     <= 32'h0;
    end else begin
      if (mem_arvalid && m_arready) begin
        m_rvalid             <= 1'b1;
        m_rdata              <= m_mem[idx(mem_araddr)];
        ar_log[ar_cnt[3:0]]  <= mem_araddr;
        ar_cnt               <= ar_cnt + 1;
      end else if (m_rvalid && mem_rready) begin
        m_rvalid <= 1'b0;
      end
      if (mem_awvalid && mem_wvalid && m_awready && m_wready) begin
        m_mem[idx(mem_awaddr)] <= merge(m_mem[idx(mem_awaddr)], mem_wdata, mem_wstrb);
        m_bvalid               <= 1'b1;
        w_cnt                  <= w_cnt + 1;
      end else if (m_bvalid && mem_bready) begin
        m_bvalid <= 1'b0;
      end
    end
    if (!reset && fp_mem_arvalid) fp_ar_cnt <= fp_ar_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ifu_arvalid = 0; ifu_araddr = 0; ifu_rready = 1;
    lsu_arvalid = 0; lsu_araddr = 0; lsu_rready = 1;
    lsu_awvalid = 0; lsu_awaddr = 0; lsu_wvalid = 0; lsu_wdata = 0; lsu_wstrb = 0;
    lsu_bready = 1;
  endtask

  task automatic do_reset(input bit check);
    @(negedge clock);
    reset = 1'b1;
    idle_inputs();
    @(negedge clock);
    #1;
    if (check) begin
      chk("rst mem_arvalid", {31'b0, mem_arvalid}, 0);
      chk("rst mem_rready", {31'b0, mem_rready}, 0);
      chk("rst mem_aw_w_valid", {30'b0, mem_awvalid, mem_wvalid}, 0);
      chk("rst mem_bready", {31'b0, mem_bready}, 0);
      chk("rst up_arready", {30'b0, ifu_arready, lsu_arready}, 0);
      chk("rst up_rvalid", {30'b0, ifu_rvalid, lsu_rvalid}, 0);
      chk("rst lsu_aw_w_b", {29'b0, lsu_awready, lsu_wready, lsu_bvalid}, 0);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        lv;
    logic [31:0] la;
    logic        e_iar;
    logic        e_lar;
    logic        e_irv;
    logic        e_lrv;
    logic        e_marv;
    logic [31:0] e_maddr;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t t_ifu [4];
  vec_t t_rr  [9];

  task automatic run_vec(input string tag, input vec_t v);
    @(negedge clock);
    ifu_arvalid = v.iv; ifu_araddr = v.ia;
    lsu_arvalid = v.lv; lsu_araddr = v.la;
    #1;
    chk({tag, " ifu_arready"}, {31'b0, ifu_arready}, {31'b0, v.e_iar});
    chk({tag, " lsu_arready"}, {31'b0, lsu_arready}, {31'b0, v.e_lar});
    chk({tag, " ifu_rvalid"}, {31'b0, ifu_rvalid}, {31'b0, v.e_irv});
    chk({tag, " lsu_rvalid"}, {31'b0, lsu_rvalid}, {31'b0, v.e_lrv});
    chk({tag, " mem_arvalid"}, {31'b0, mem_arvalid}, {31'b0, v.e_marv});
    if (v.e_marv) chk({tag, " mem_araddr"}, mem_araddr, v.e_maddr);
    if (v.e_irv) chk({tag, " ifu_rdata"}, ifu_rdata, v.e_rdata);
    if (v.e_lrv) chk({tag, " lsu_rdata"}, lsu_rdata, v.e_rdata);
  endtask

  initial begin
    int ar0, w0, fp0;

    // IFU-only read: arready on cycle 1, rvalid on cycle 2
    t_ifu[0] = '{1'b1, 32'h8000_0000, 1'b0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0};
    t_ifu[1] = '{1'b1, 32'h8000_0000, 1'b0, 32'h0, 1, 0, 0, 0, 1, 32'h8000_0000, 32'h0};
    t_ifu[2] = '{1'b0, 32'h0, 1'b0, 32'h0, 0, 0, 1, 0, 0, 32'h0, 32'h0000_0413};
    t_ifu[3] = '{1'b0, 32'h0, 1'b0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0};
    // Round-robin: tie -> IFU, then LSU, then tie -> IFU again
    t_rr[0] = '{1'b1, 32'h100, 1'b1, 32'h200, 0, 0, 0, 0, 0, 32'h0, 32'h0};
    t_rr[1] = '{1'b1, 32'h100, 1'b1, 32'h200, 1, 0, 0, 0, 1, 32'h100, 32'h0};
    t_rr[2] = '{1'b0, 32'h0, 1'b1, 32'h200, 0, 0, 1, 0, 0, 32'h0, 32'h1111_1111};
    t_rr[3] = '{1'b0, 32'h0, 1'b1, 32'h200, 0, 0, 0, 0, 0, 32'h0, 32'h0};
    t_rr[4] = '{1'b0, 32'h0, 1'b1, 32'h200, 0, 1, 0, 0, 1, 32'h200, 32'h0};
    t_rr[5] = '{1'b0, 32'h0, 1'b0, 32'h0, 0, 0, 0, 1, 0, 32'h0, 32'h2222_2222};
    t_rr[6] = '{1'b1, 32'h100, 1'b1, 32'h200, 0, 0, 0, 0, 0, 32'h0, 32'h0};
    t_rr[7] = '{1'b1, 32'h100, 1'b1, 32'h200, 1, 0, 0, 0, 1, 32'h100, 32'h0};
    t_rr[8] = '{1'b0, 32'h0, 1'b0, 32'h0, 0, 0, 1, 0, 0, 32'h0, 32'h1111_1111};

    idle_inputs();
    do_reset(1'b1);

    for (int i = 0; i < 4; i++) run_vec($sformatf("ifu[%0d]", i), t_ifu[i]);

    do_reset(1'b0);
    ar0 = ar_cnt;
    for (int i = 0; i < 9; i++) run_vec($sformatf("rr[%0d]", i), t_rr[i]);
    chk("rr ar count", ar_cnt - ar0, 3);
    chk("rr ar order 0", ar_log[ar0[3:0]], 32'h100);
    chk("rr ar order 1", ar_log[4'(ar0 + 1)], 32'h200);
    chk("rr ar order 2", ar_log[4'(ar0 + 2)], 32'h100);

    // Fixed priority: both requesting continuously, LSU wins every time
    do_reset(1'b0);
    fp0 = fp_ar_cnt;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      ifu_arvalid = 1; ifu_araddr = 32'h100;
      lsu_arvalid = 1; lsu_araddr = 32'h200;
      #1;
      chk("fp ifu_arready", {31'b0, fp_ifu_arready}, 0);
      if (fp_mem_arvalid) chk("fp mem_araddr", fp_mem_araddr, 32'h200);
    end
    chk("fp ar count", fp_ar_cnt - fp0, 4);

    // Store then load to the same address, raised together
    do_reset(1'b0);
    ar0 = ar_cnt;
    w0 = w_cnt;
    @(negedge clock);
    lsu_awvalid = 1; lsu_wvalid = 1; lsu_awaddr = 32'h1000; lsu_wdata = 32'hDEAD_BEEF;
    lsu_wstrb = 4'hF; lsu_bready = 1;
    lsu_arvalid = 1; lsu_araddr = 32'h1000;
    #1;
    chk("wr c0 mem_awvalid", {31'b0, mem_awvalid}, 1);
    chk("wr c0 mem_awaddr", mem_awaddr, 32'h1000);
    chk("wr c0 mem_wstrb", {28'b0, mem_wstrb}, 32'hF);
    chk("wr c0 lsu_aw_w_ready", {30'b0, lsu_awready, lsu_wready}, 3);
    chk("wr c0 mem_arvalid", {31'b0, mem_arvalid}, 0);
    @(negedge clock);
    lsu_awvalid = 0; lsu_wvalid = 0;
    #1;
    chk("wr c1 lsu_bvalid", {31'b0, lsu_bvalid}, 1);
    chk("wr c1 lsu_awready", {31'b0, lsu_awready}, 0);
    chk("wr c1 mem_arvalid", {31'b0, mem_arvalid}, 0);
    @(negedge clock);
    #1;
    chk("wr c2 lsu_bvalid", {31'b0, lsu_bvalid}, 0);
    chk("wr c2 mem_arvalid", {31'b0, mem_arvalid}, 0);
    @(negedge clock);
    #1;
    chk("wr c3 mem_arvalid", {31'b0, mem_arvalid}, 1);
    chk("wr c3 mem_araddr", mem_araddr, 32'h1000);
    chk("wr c3 lsu_arready", {31'b0, lsu_arready}, 1);
    @(negedge clock);
    lsu_arvalid = 0;
    #1;
    chk("wr c4 lsu_rvalid", {31'b0, lsu_rvalid}, 1);
    chk("wr c4 lsu_rdata", lsu_rdata, 32'hDEAD_BEEF);
    chk("wr write count", w_cnt - w0, 1);
    chk("wr ar count", ar_cnt - ar0, 1);

    // Write with valids held and bready low after the handshake
    do_reset(1'b0);
    w0 = w_cnt;
    @(negedge clock);
    lsu_awvalid = 1; lsu_wvalid = 1; lsu_awaddr = 32'h2000; lsu_wdata = 32'h1234_5678;
    lsu_wstrb = 4'hF; lsu_bready = 0;
    #1;
    chk("hold c0 mem_wvalid", {31'b0, mem_wvalid}, 1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      #1;
      chk("hold mem_awvalid", {31'b0, mem_awvalid}, 0);
      chk("hold lsu_bvalid", {31'b0, lsu_bvalid}, 1);
    end
    @(negedge clock);
    lsu_bready = 1; lsu_awvalid = 0; lsu_wvalid = 0;
    #1;
    chk("hold c6 mem_bready", {31'b0, mem_bready}, 1);
    @(negedge clock);
    #1;
    chk("hold c7 lsu_bvalid", {31'b0, lsu_bvalid}, 0);
    chk("hold write count", w_cnt - w0, 1);

    // Reset while a read response is pending
    do_reset(1'b0);
    @(negedge clock);
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0000; ifu_rready = 0;
    @(negedge clock);
    #1;
    chk("mrst ifu_arready", {31'b0, ifu_arready}, 1);
    @(negedge clock);
    ifu_arvalid = 0;
    #1;
    chk("mrst pending rvalid", {31'b0, ifu_rvalid}, 1);
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    #1;
    chk("mrst after ifu_rvalid", {31'b0, ifu_rvalid}, 0);
    chk("mrst after lsu_rvalid", {31'b0, lsu_rvalid}, 0);
    reset = 0;
    ifu_rready = 1;
    for (int i = 0; i < 4; i++) run_vec($sformatf("post[%0d]", i), t_ifu[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_arbiter.md
# axi_arbiter

Two-master, one-slave AXI-lite arbiter in front of the simulation memory port. It merges the instruction-fetch read channel (ifu) and the load/store unit read and write channels (lsu) onto the single memory read/write interface (mem). Read grants are round-robin or fixed-priority, one outstanding single-beat transaction per channel. Downstream valids are gated so each request is presented to memory exactly once.

## Interface
- RR_EN, default 1: 1 = round-robin read arbitration; 0 = fixed priority, lsu wins ties.
- clock  input  1  system clock.
- reset  input  1  reset, synchronous, active-high.
- ifu_r_m2s  input  axi_r_m2s_t  IFU read request: arvalid, araddr, rready.
- ifu_r_s2m  output  axi_r_s2m_t  IFU read response: arready, rvalid, rdata, rlast.
- lsu_r_m2s  input  axi_r_m2s_t  LSU read request.
- lsu_r_s2m  output  axi_r_s2m_t  LSU read response.
- lsu_w_m2s  input  axi_w_m2s_t  LSU write: awvalid, awaddr, wvalid, wdata, wstrb, bready.
- lsu_w_s2m  output  axi_w_s2m_t  LSU write response: awready, wready, bvalid.
- mem_r_m2s  output  axi_r_m2s_t  read request to memory.
- mem_r_s2m  input  axi_r_s2m_t  read response from memory.
- mem_w_m2s  output  axi_w_m2s_t  write request to memory.
- mem_w_s2m  input  axi_w_s2m_t  write response from memory.

## Operation
- Read FSM states: R_IDLE, R_ADDR, R_DATA. Registered `grant` (IFU/LSU) and `last` pointer.
- R_IDLE:
  - Candidates are ifu arvalid, and lsu arvalid only while the write FSM is W_IDLE (store-before-load ordering).
  - With one candidate, grant it. With both: RR_EN=1 grants the master not equal to `last`; RR_EN=0 grants LSU.
  - Go to R_ADDR and latch `last` := grant.
  - All upstream arready and rvalid are 0, and mem arvalid is 0.
- R_ADDR:
  - mem arvalid = granted arvalid; mem araddr = granted araddr.
  - Granted arready = mem arready; non-granted arready = 0.
  - On mem arvalid & arready, go to R_DATA.
- R_DATA:
  - mem arvalid = 0; mem rready = granted rready.
  - Granted rvalid = mem rvalid; non-granted rvalid = 0.
  - rdata and rlast are broadcast to both masters.
  - On mem rvalid & rready, go to R_IDLE.
- Write FSM states: W_IDLE, W_RESP.
- W_IDLE:
  - Forward lsu awvalid, wvalid, awaddr, wdata and wstrb to mem.
  - lsu awready = mem awready; lsu wready = mem wready; mem bready = 0; lsu bvalid = 0.
  - When all four of mem awvalid, wvalid, awready and wready are high, go to W_RESP.
- W_RESP:
  - mem awvalid = wvalid = 0; lsu awready = wready = 0.
  - lsu bvalid = mem bvalid; mem bready = lsu bready.
  - On bvalid & bready, go to W_IDLE.
- Read and write FSMs are independent except for the LSU read hold while write ≠ W_IDLE. An IFU read may run concurrently with an LSU write.
- All outputs are combinational from state and inputs, with no extra register stage on data.

## Timing
- Reset: both FSMs idle, grant = IFU, `last` = LSU (first tie goes to IFU).
- Reset output values: all outputs to mem are valid/ready = 0, and all upstream arready, rvalid, awready, wready and bvalid are 0. While reset is held, mem awvalid/wvalid forward lsu's inputs combinationally.
- Read, with memory ready on the first cycle:
  - Cycle 0: arvalid sampled in R_IDLE.
  - Cycle 1: AR handshake.
  - Cycle 2: rvalid is visible upstream.
  - Cycle 3: earliest next grant. Sustained throughput is 1 read per 3 cycles.
- Write: the AW/W handshake happens in the cycle both valids are seen (0 added latency). bvalid passes through the next cycle.
- Upstream must hold arvalid and araddr until arready. A master deasserting arvalid while it is granted in R_ADDR is illegal and is not handled.
- Reset mid-transaction: FSMs return to idle in the next cycle and the in-flight transaction is abandoned without a response. Memory is reset by the same signal.

## Test plan
- IFU-only read at 0x8000_0000, mem returns 0x0000_0413 → ifu arready pulses on cycle 1, ifu rvalid with rdata 0x0000_0413 on cycle 2, lsu rvalid stays 0.
- IFU and LSU arvalid together from reset, RR_EN=1, addresses 0x100/0x200 → mem sees 0x100 then 0x200 as exactly one arvalid handshake each. A third simultaneous pair is granted IFU again.
- RR_EN=0, both masters continuously requesting → every grant goes to LSU; ifu arready stays 0 throughout.
- LSU write 0x1000 ← 0xDEADBEEF with wstrb 0xF, plus an LSU read of 0x1000 raised the same cycle → exactly one mem write. The read's AR is issued only after lsu bvalid & bready, and rdata = 0xDEADBEEF.
- LSU holds awvalid/wvalid high and bready low for 5 cycles after the handshake → exactly one mem write; lsu bvalid stays high until bready.
- Reset asserted while in R_DATA with mem rvalid pending → the cycle after, all upstream rvalid are 0 and the next IFU request is serviced normally.
